// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between the fetch stage and
// the memory stage of the MIPS pipeline. At most one transaction is in
// flight at a time. Each side receives a one-cycle ready pulse when its
// access completes. Addresses and data pass through unmodified.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  // fetch side
  input  logic          IEnF,
  input  logic [AW-1:0] IAddrF,
  output logic [DW-1:0] IDataF,
  output logic          IReadyF,
  // data side
  input  logic          DEnM,
  input  logic          MemWriteM,
  input  logic [AW-1:0] DAddrM,
  input  logic [DW-1:0] DWDataM,
  output logic [DW-1:0] DRDataM,
  output logic          DReadyM,
  // memory port
  output logic          MemReq,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemAck
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t state;
  logic   last_gnt;
  logic   fetch_flushed;
  logic   grant_i;
  logic   grant_d;

  // Choose which side (if any) gets the memory port at the coming edge.
  // In DONE the side that just finished still holds its enable, so only
  // the other side is eligible there.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (IEnF && DEnM) begin
          grant_d = (last_gnt == SIDE_I);
          grant_i = (last_gnt == SIDE_D);
        end else begin
          grant_i = IEnF;
          grant_d = DEnM;
        end
      end
      DONE: begin
        grant_d = (last_gnt == SIDE_I) && DEnM;
        grant_i = (last_gnt == SIDE_D) && IEnF;
      end
      default: begin
        grant_i = 1'b0;
        grant_d = 1'b0;
      end
    endcase
  end

  // Arbiter state machine; every output is a register updated here.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      last_gnt      <= SIDE_I;
      fetch_flushed <= 1'b0;
      MemReq        <= 1'b0;
      MemWE         <= 1'b0;
      MemAddr       <= '0;
      MemWData      <= '0;
      IDataF        <= '0;
      DRDataM       <= '0;
      IReadyF       <= 1'b0;
      DReadyM       <= 1'b0;
    end else begin
      IReadyF <= 1'b0;
      DReadyM <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant_i) begin
            MemReq        <= 1'b1;
            MemWE         <= 1'b0;
            MemAddr       <= IAddrF;
            last_gnt      <= SIDE_I;
            fetch_flushed <= 1'b0;
            state         <= BUSY_I;
          end else if (grant_d) begin
            MemReq   <= 1'b1;
            MemWE    <= MemWriteM;
            MemAddr  <= DAddrM;
            MemWData <= DWDataM;
            last_gnt <= SIDE_D;
            state    <= BUSY_D;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_I: begin
          if (!IEnF) begin
            fetch_flushed <= 1'b1;
          end
          if (MemAck) begin
            MemReq <= 1'b0;
            MemWE  <= 1'b0;
            if (IEnF && !fetch_flushed) begin
              IDataF  <= MemRData;
              IReadyF <= 1'b1;
            end
            state <= DONE;
          end
        end
        BUSY_D: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            MemWE  <= 1'b0;
            if (!MemWE) begin
              DRDataM <= MemRData;
            end
            DReadyM <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
